wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writeback arbiter and driver for the register-file write port (we3/wa3/wd3).
//  Merges single-cycle ALU results with long-latency (load/mul/div) results buffered in a FIFO.
//  Keeps a per-register busy scoreboard for the issue stage.
//  Outputs are registered on posedge clk, so they are stable when the register file samples on negedge.
// PARAMETERS
//  DEPTH        4   long-latency result FIFO entries; power of 2, >=2
//  STARVE_LIMIT 8   consecutive unserved cycles of a non-empty FIFO before alu_stall
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst_n      in   1   asynchronous active-low reset
//  alu_valid  in   1   ALU result present this cycle; no backpressure
//  alu_rd     in   5   ALU destination register
//  alu_data   in   32  ALU result
//  mc_valid   in   1   long-latency result offered
//  mc_ready   out  1   FIFO can accept; = !full (combinational from state)
//  mc_rd      in   5   long-latency destination register
//  mc_data    in   32  long-latency result
//  issue_valid in  1   long-latency op issued this cycle
//  issue_rd   in   5   its destination; sets busy
//  busy       out  32  scoreboard; bit i = write to xi outstanding; bit 0 always 0
//  alu_stall  out  1   registered request: upstream holds alu_valid=0 while high
//  we3        out  1   register-file write enable (registered)
//  wa3        out  5   register-file write address (registered)
//  wd3        out  32  register-file write data (registered)
// BEHAVIOUR
//  - Reset (async, rst_n=0): we3=0, wa3=0, wd3=0, FIFO emptied, busy=0, starve cnt=0, alu_stall=0.
//    mc_ready=1 while in reset. Reset mid-operation discards all FIFO contents and busy bits.
//  - Push: mc_valid && mc_ready at posedge. A push with mc_rd=0 is accepted and discarded:
//    no FIFO entry is written, and no count change.
//  - Arbitration each cycle, fixed priority:
//    (1) alu_valid && alu_rd!=0 -> ALU wins.
//    (2) else FIFO non-empty -> pop head.
//    (3) else idle.
//  - Winner is registered at posedge: we3=1, wa3=rd, wd3=data for exactly the following cycle.
//    Idle -> we3=0, with wa3/wd3 holding their previous values.
//  - Latency: ALU = 1 cycle. An entry pushed at edge k is eligible at edge k+1 (earliest we3 is in cycle k+1).
//    No same-edge push-and-pop of the same entry.
//  - Simultaneous push and pop on a full FIFO: the pop frees the slot, but mc_ready is computed from pre-edge state, so it stays 0 that cycle.
//  - FIFO order is strict FIFO; pointers wrap modulo DEPTH; occupancy counter is $clog2(DEPTH)+1 bits.
//  - Scoreboard:
//    - issue_valid && issue_rd!=0 sets busy[issue_rd] at posedge.
//    - A FIFO pop with rd=r clears busy[r] at the same edge that registers we3 for it.
//    - Set and clear of the same bit at the same edge -> set wins.
//    - ALU writes never touch busy.
//  - WAW ordering between ALU and FIFO for the same rd is the issue stage's responsibility (use busy).
//  - Starvation:
//    - cnt increments each cycle the FIFO is non-empty and not popped; it saturates at STARVE_LIMIT.
//    - cnt clears on pop or when the FIFO is empty.
//    - alu_stall is high while cnt==STARVE_LIMIT.
//    - If alu_valid arrives while alu_stall=1, the ALU still wins (no data loss); cnt stays saturated.
// CONFIGURATION
//  WB_BYPASS_EN defined:
//    - adds outputs byp_valid(1), byp_rd(5), byp_data(32).
//    - These are a combinational copy of this cycle's arbitration winner, i.e. next cycle's we3/wa3/wd3, for forwarding.
//    - byp_valid=0 when idle.
//  WB_BYPASS_EN undefined: these ports and their logic do not exist; all other behaviour is identical.
// TESTING
//  1. Release reset; alu_valid=1 rd=5 data=32'hDEADBEEF for one cycle -> next cycle we3=1 wa3=5 wd3=DEADBEEF, then we3=0.
//  2. issue rd=7; later push mc rd=7 data=32'h1234 with ALU idle -> busy[7]=1 from the issue edge;
//     we3=1 wa3=7 wd3=1234 in the cycle after the push edge; busy[7]=0 in that same cycle.
//  3. Hold alu_valid (rd=1), push 4 entries -> mc_ready=0 after the 4th push; 5th offer not accepted;
//     alu_stall=1 after 8 unserved cycles; drop alu_valid -> 4 writes in push order on consecutive cycles; mc_ready=1 again.
//  4. alu_valid rd=3 data=A in the same cycle FIFO head is rd=3 data=B -> we3 wa3=3 wd3=A, then next cycle wd3=B; busy[3] clears with B.
//  5. alu rd=0 and mc push rd=0 -> we3 stays 0; push accepted (mc_ready=1), occupancy unchanged; busy unchanged.
//  6. FIFO holding 2 entries, busy=0x0000_0090; pulse rst_n=0 mid-cycle -> we3=0, busy=0, mc_ready=1 immediately; no writes after release.

Source files
------------

// File: rtl/wb_arbiter.sv
// Writeback arbiter for the register-file write port (we3/wa3/wd3).
// Single-cycle ALU results take priority over long-latency results, which
// wait in a small FIFO. A per-register busy scoreboard tracks outstanding
// long-latency writes. A starvation counter raises alu_stall so that
// FIFO entries cannot wait forever.
// Optional feature: define WB_BYPASS_EN to add the byp_valid/byp_rd/byp_data
// forwarding outputs.
module wb_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        mc_valid,
  output logic        mc_ready,
  input  logic [4:0]  mc_rd,
  input  logic [31:0] mc_data,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic [31:0] busy,
  output logic        alu_stall,
  output logic        we3,
  output logic [4:0]  wa3,
  output logic [31:0] wd3
`ifdef WB_BYPASS_EN
  ,
  output logic        byp_valid,
  output logic [4:0]  byp_rd,
  output logic [31:0] byp_data
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [4:0]    fifo_rd_q   [DEPTH];
  logic [4:0]    fifo_rd_d   [DEPTH];
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_data_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          alu_stall_q, alu_stall_d;
  logic [31:0]   busy_q, busy_d;
  logic          we3_q, we3_d;
  logic [4:0]    wa3_q, wa3_d;
  logic [31:0]   wd3_q, wd3_d;

  logic        full, empty, alu_win, pop, push;
  logic [4:0]  head_rd;
  logic [31:0] head_data;
  logic        win_valid;
  logic [4:0]  win_rd;
  logic [31:0] win_data;
  logic [31:0] busy_set, busy_clr;

  // Arbitration, FIFO bookkeeping, scoreboard and starvation next-state.
  always_comb begin
    full      = (cnt_q == FULL_CNT);
    empty     = (cnt_q == '0);
    alu_win   = alu_valid && (alu_rd != 5'd0);
    pop       = !alu_win && !empty;
    // rd=0 offers are handshaken but never stored
    push      = mc_valid && !full && (mc_rd != 5'd0);
    head_rd   = fifo_rd_q[rd_ptr_q];
    head_data = fifo_data_q[rd_ptr_q];

    win_valid = alu_win || pop;
    win_rd    = alu_win ? alu_rd : head_rd;
    win_data  = alu_win ? alu_data : head_data;

    we3_d = win_valid;
    wa3_d = win_valid ? win_rd : wa3_q;
    wd3_d = win_valid ? win_data : wd3_q;

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    busy_set = (issue_valid && (issue_rd != 5'd0)) ? (32'd1 << issue_rd) : 32'd0;
    busy_clr = pop ? (32'd1 << head_rd) : 32'd0;
    // set is applied after clear so a same-edge re-issue keeps the bit
    busy_d   = ((busy_q & ~busy_clr) | busy_set) & ~32'd1;

    starve_d = starve_q;
    if (empty || pop)
      starve_d = '0;
    else if (starve_q != STARVE_MAX)
      starve_d = starve_q + SW'(1);
    alu_stall_d = (starve_d == STARVE_MAX);
  end

  // FIFO storage next-state: write the tail slot on an accepted push.
  always_comb begin
    fifo_rd_d   = fifo_rd_q;
    fifo_data_d = fifo_data_q;
    if (push) begin
      fifo_rd_d[wr_ptr_q]   = mc_rd;
      fifo_data_d[wr_ptr_q] = mc_data;
    end
  end

  // State registers; reset flushes the FIFO, scoreboard and write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= '0;
        fifo_data_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      alu_stall_q <= 1'b0;
      busy_q      <= '0;
      we3_q       <= 1'b0;
      wa3_q       <= '0;
      wd3_q       <= '0;
    end else begin
      fifo_rd_q   <= fifo_rd_d;
      fifo_data_q <= fifo_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      alu_stall_q <= alu_stall_d;
      busy_q      <= busy_d;
      we3_q       <= we3_d;
      wa3_q       <= wa3_d;
      wd3_q       <= wd3_d;
    end
  end

  assign mc_ready  = !full;
  assign busy      = busy_q;
  assign alu_stall = alu_stall_q;
  assign we3       = we3_q;
  assign wa3       = wa3_q;
  assign wd3       = wd3_q;

`ifdef WB_BYPASS_EN
  // Forwarding view of this cycle's winner, i.e. next cycle's write port.
  assign byp_valid = win_valid;
  assign byp_rd    = win_rd;
  assign byp_data  = win_data;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter with hand-computed expected values.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mc_valid = 1'b0;
  logic        mc_ready;
  logic [4:0]  mc_rd = '0;
  logic [31:0] mc_data = '0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic [31:0] busy;
  logic        alu_stall;
  logic        we3;
  logic [4:0]  wa3;
  logic [31:0] wd3;
`ifdef WB_BYPASS_EN
  logic        byp_valid;
  logic [4:0]  byp_rd;
  logic [31:0] byp_data;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd(mc_rd), .mc_data(mc_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .busy(busy), .alu_stall(alu_stall),
    .we3(we3), .wa3(wa3), .wd3(wd3)
`ifdef WB_BYPASS_EN
    ,
    .byp_valid(byp_valid), .byp_rd(byp_rd), .byp_data(byp_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wr(input string tag, input logic v, input logic [4:0] a, input logic [31:0] d);
    check({tag, "_we3"}, 32'(we3), 32'(v));
    check({tag, "_wa3"}, 32'(wa3), 32'(a));
    check({tag, "_wd3"}, 32'(wd3), d);
  endtask

  initial begin
    // reset state
    #12;
    check("rst_we3", 32'(we3), 32'd0);
    check("rst_wa3", 32'(wa3), 32'd0);
    check("rst_wd3", wd3, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_ready", 32'(mc_ready), 32'd1);
    check("rst_stall", 32'(alu_stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1: single ALU write
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
    step();
    chk_wr("t1_wr", 1'b1, 5'd5, 32'hDEADBEEF);
    alu_valid = 1'b0;
    step();
    chk_wr("t1_idle", 1'b0, 5'd5, 32'hDEADBEEF);

    // 2: issue sets busy, FIFO pop clears it
    issue_valid = 1'b1; issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    check("t2_busy_set", busy, 32'h0000_0080);
    mc_valid = 1'b1; mc_rd = 5'd7; mc_data = 32'h1234;
    step();
    mc_valid = 1'b0;
    check("t2_push_we3", 32'(we3), 32'd0);
    check("t2_busy_hold", busy, 32'h0000_0080);
    step();
    chk_wr("t2_pop", 1'b1, 5'd7, 32'h1234);
    check("t2_busy_clr", busy, 32'd0);
    step();
    check("t2_idle_we3", 32'(we3), 32'd0);

    // 3: fill FIFO under continuous ALU traffic, starvation, drain
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_ready_pre%0d", i), 32'(mc_ready), 32'd1);
      mc_valid = 1'b1; mc_rd = 5'(10 + i); mc_data = 32'hA0 + 32'(i);
      step();
      chk_wr($sformatf("t3_alu%0d", i), 1'b1, 5'd1, 32'h11);
    end
    check("t3_full_ready", 32'(mc_ready), 32'd0);
    mc_rd = 5'd14; mc_data = 32'hBAD;
    step();
    mc_valid = 1'b0;
    check("t3_still_full", 32'(mc_ready), 32'd0);
    check("t3_stall_e5", 32'(alu_stall), 32'd0);
    step(); step(); step();
    check("t3_stall_e8", 32'(alu_stall), 32'd0);
    step();
    check("t3_stall_e9", 32'(alu_stall), 32'd1);
    step();
    check("t3_stall_e10", 32'(alu_stall), 32'd1);
    chk_wr("t3_alu_wins", 1'b1, 5'd1, 32'h11);
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk_wr($sformatf("t3_drain%0d", i), 1'b1, 5'(10 + i), 32'hA0 + 32'(i));
      check($sformatf("t3_ready_drain%0d", i), 32'(mc_ready), 32'd1);
      check($sformatf("t3_stall_drain%0d", i), 32'(alu_stall), 32'd0);
    end
    step();
    check("t3_empty_we3", 32'(we3), 32'd0);

    // 4: ALU and FIFO head target the same rd
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    issue_valid = 1'b0;
    mc_valid = 1'b1; mc_rd = 5'd3; mc_data = 32'hBBBB;
    step();
    mc_valid = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA;
    step();
    alu_valid = 1'b0;
    chk_wr("t4_alu", 1'b1, 5'd3, 32'hAAAA);
    check("t4_busy_alu", busy, 32'h0000_0008);
    step();
    chk_wr("t4_fifo", 1'b1, 5'd3, 32'hBBBB);
    check("t4_busy_clr", busy, 32'd0);

    // 5: rd=0 on both sources
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h5555;
    mc_valid = 1'b1; mc_rd = 5'd0; mc_data = 32'h6666;
    #1;
    check("t5_ready", 32'(mc_ready), 32'd1);
    step();
    alu_valid = 1'b0; mc_valid = 1'b0;
    check("t5_we3_a", 32'(we3), 32'd0);
    check("t5_ready_after", 32'(mc_ready), 32'd1);
    step();
    check("t5_we3_b", 32'(we3), 32'd0);
    check("t5_busy", busy, 32'd0);

    // 6: reset mid-operation with two entries queued
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h11;
    issue_valid = 1'b1; issue_rd = 5'd4;
    step();
    issue_rd = 5'd7;
    step();
    issue_valid = 1'b0;
    mc_valid = 1'b1; mc_rd = 5'd4; mc_data = 32'h44;
    step();
    mc_rd = 5'd7; mc_data = 32'h77;
    step();
    mc_valid = 1'b0;
    check("t6_busy_pre", busy, 32'h0000_0090);
    check("t6_we3_pre", 32'(we3), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_we3", 32'(we3), 32'd0);
    check("t6_rst_busy", busy, 32'd0);
    check("t6_rst_ready", 32'(mc_ready), 32'd1);
    alu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t6_post_we3_%0d", i), 32'(we3), 32'd0);
    end

    // set wins over clear on the same bit at the same edge
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0;
    mc_valid = 1'b1; mc_rd = 5'd9; mc_data = 32'h99;
    step();
    mc_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    issue_valid = 1'b0;
    chk_wr("t7_pop", 1'b1, 5'd9, 32'h99);
    check("t7_busy_setwins", busy, 32'h0000_0200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
